branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/mips_pipe_pkg.sv | 24 ++
 rtl/sat_counter.sv | 19 +
 rtl/branch_resolver.sv | 151 +++++++++++++++
 tb/tb_branch_resolver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: register index width, branch FSM states and
// hazard stall depths used by the ID-stage branch logic.
package mips_pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STALL_W = 2;

    // A load in EX needs two cycles before its data reaches the ID comparator
    localparam logic [STALL_W-1:0] LOAD_EX_STALLS = STALL_W'(2);
    localparam logic [STALL_W-1:0] OTHER_STALLS   = STALL_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } br_state_t;

    // Register 0 is hardwired, so it never creates a dependency
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolution: stalls on data hazards feeding the early
// comparator, then redirects the PC and keeps taken/not-taken statistics.
module branch_resolver
    import mips_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_is_beq,
    input  logic             id_is_bne,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             cmp_zero,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             pipe_flush,
    output logic             stall,
    output logic             pc_src,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    br_state_t          state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic               type_q, type_d;
    logic [STALL_W-1:0] need;
    logic               is_branch;
    logic               ex_hit;
    logic               mem_hit;
    logic               resolve;
    logic               beq_sel;
    logic               taken;
    logic               inc_taken;
    logic               inc_nottaken;

    // Required stall depth: worst case over the outstanding producers
    always_comb begin
        is_branch = id_valid && (id_is_beq || id_is_bne);
        ex_hit    = reg_hit(id_rs, ex_rd) || reg_hit(id_rt, ex_rd);
        mem_hit   = reg_hit(id_rs, mem_rd) || reg_hit(id_rt, mem_rd);
        need      = '0;
        if (mem_mem_read && mem_hit) begin
            need = OTHER_STALLS;
        end
        if (ex_reg_write && !ex_mem_read && ex_hit) begin
            need = OTHER_STALLS;
        end
        if (ex_mem_read && ex_hit) begin
            need = LOAD_EX_STALLS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        if (pipe_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_branch && (need != '0)) begin
                        cnt_d   = need - STALL_W'(1);
                        type_d  = id_is_beq;
                        state_d = ((need - STALL_W'(1)) != '0) ? STALL : RESOLVE;
                    end
                end
                STALL: begin
                    cnt_d = cnt_q - STALL_W'(1);
                    if (cnt_q == STALL_W'(1)) begin
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so they drop the instant reset rises
    always_comb begin
        stall        = 1'b0;
        pc_src       = 1'b0;
        ifid_flush   = 1'b0;
        inc_taken    = 1'b0;
        inc_nottaken = 1'b0;
        resolve      = 1'b0;
        beq_sel      = 1'b0;
        if (!reset && !pipe_flush) begin
            case (state_q)
                IDLE: begin
                    if (is_branch) begin
                        if (need != '0) begin
                            stall = 1'b1;
                        end else begin
                            resolve = 1'b1;
                            beq_sel = id_is_beq;
                        end
                    end
                end
                STALL: stall = 1'b1;
                RESOLVE: begin
                    resolve = 1'b1;
                    beq_sel = type_q;
                end
                default: stall = 1'b0;
            endcase
        end
        taken = beq_sel ? cmp_zero : !cmp_zero;
        if (resolve) begin
            pc_src       = taken;
            ifid_flush   = taken;
            inc_taken    = taken;
            inc_nottaken = !taken;
        end
    end

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_taken),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_nottaken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_nottaken),
        .count (nottaken_cnt)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hazard stalls, immediate resolution,
// flush/reset abort and counter saturation, with hand-computed expectations.
module tb_branch_resolver;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_is_beq;
    logic        id_is_bne;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        cmp_zero;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_mem_read;
    logic [4:0]  mem_rd;
    logic        pipe_flush;
    logic        stall;
    logic        pc_src;
    logic        ifid_flush;
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolver #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_is_beq    (id_is_beq),
        .id_is_bne    (id_is_bne),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .cmp_zero     (cmp_zero),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .pipe_flush   (pipe_flush),
        .stall        (stall),
        .pc_src       (pc_src),
        .ifid_flush   (ifid_flush),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_valid     = 1'b0;
        id_is_beq    = 1'b0;
        id_is_bne    = 1'b0;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        cmp_zero     = 1'b0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = 5'd0;
        mem_mem_read = 1'b0;
        mem_rd       = 5'd0;
        pipe_flush   = 1'b0;
    endtask

    task automatic br(input logic beq, input logic [4:0] rs, input logic [4:0] rt, input logic cz);
        id_valid  = 1'b1;
        id_is_beq = beq;
        id_is_bne = !beq;
        id_rs     = rs;
        id_rt     = rt;
        cmp_zero  = cz;
    endtask

    task automatic outs(input string tag, input logic s, input logic p, input logic f);
        chk({tag, "_stall"}, 32'(stall), 32'(s));
        chk({tag, "_pc_src"}, 32'(pc_src), 32'(p));
        chk({tag, "_ifid_flush"}, 32'(ifid_flush), 32'(f));
    endtask

    task automatic cnts(input string tag, input logic [15:0] t, input logic [15:0] n);
        chk({tag, "_taken"}, 32'(taken_cnt), 32'(t));
        chk({tag, "_nottaken"}, 32'(nottaken_cnt), 32'(n));
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #2;
        br(1'b1, 5'd3, 5'd4, 1'b1);
        #1;
        outs("reset_hold", 1'b0, 1'b0, 1'b0);
        cnts("reset_hold", 16'd0, 16'd0);
        clr();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // BEQ, no hazards, equal operands: taken in the same cycle
        br(1'b1, 5'd3, 5'd4, 1'b1);
        #1 outs("beq_imm", 1'b0, 1'b1, 1'b1);
        @(negedge clk); clr(); #1;
        cnts("beq_imm", 16'd1, 16'd0);

        // BNE behind a load in EX: two stall cycles then not-taken
        br(1'b0, 5'd5, 5'd6, 1'b1);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        #1 outs("bne_ld_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        outs("bne_ld_c1", 1'b1, 1'b0, 1'b0);
        cnts("bne_ld_c1", 16'd1, 16'd0);
        @(negedge clk); #1;
        outs("bne_ld_res", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("bne_ld", 16'd1, 16'd1);

        // BEQ behind an ALU write on rt: one stall then taken
        br(1'b1, 5'd2, 5'd7, 1'b1);
        ex_reg_write = 1'b1; ex_rd = 5'd7;
        #1 outs("beq_alu_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        outs("beq_alu_res", 1'b0, 1'b1, 1'b1);
        @(negedge clk); clr(); #1;
        cnts("beq_alu", 16'd2, 16'd1);

        // BNE behind a load in MEM: one stall, operands differ so taken
        br(1'b0, 5'd9, 5'd10, 1'b0);
        mem_mem_read = 1'b1; mem_rd = 5'd10;
        #1 outs("bne_mem_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        outs("bne_mem_res", 1'b0, 1'b1, 1'b1);
        @(negedge clk); clr(); #1;
        cnts("bne_mem", 16'd3, 16'd1);

        // r0 never hazards: immediate, not taken
        br(1'b1, 5'd0, 5'd4, 1'b0);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
        #1 outs("beq_r0", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("beq_r0", 16'd3, 16'd2);

        br(1'b0, 5'd1, 5'd2, 1'b0);
        #1 outs("bne_imm", 1'b0, 1'b1, 1'b1);
        @(negedge clk); clr(); #1;
        cnts("bne_imm", 16'd4, 16'd2);

        // Invalid ID slot is ignored
        br(1'b1, 5'd3, 5'd4, 1'b1);
        id_valid = 1'b0;
        #1 outs("invalid", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("invalid", 16'd4, 16'd2);

        // Flush while stalling abandons the branch
        br(1'b1, 5'd5, 5'd6, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1 outs("fl_stall_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pipe_flush = 1'b1;
        #1 outs("fl_stall_fl", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("fl_stall", 16'd4, 16'd2);
        br(1'b1, 5'd3, 5'd4, 1'b1);
        #1 outs("fl_stall_idle", 1'b0, 1'b1, 1'b1);
        @(negedge clk); clr(); #1;
        cnts("fl_stall_idle", 16'd5, 16'd2);

        // Flush in the resolving cycle wins over resolution
        br(1'b1, 5'd2, 5'd7, 1'b1);
        ex_reg_write = 1'b1; ex_rd = 5'd7;
        #1 outs("fl_res_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pipe_flush = 1'b1;
        #1 outs("fl_res_fl", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("fl_res", 16'd5, 16'd2);

        // Reset mid-stall: outputs drop at once, counters clear
        br(1'b0, 5'd5, 5'd6, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1 outs("rst_stall_c0", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1 outs("rst_stall_rst", 1'b0, 1'b0, 1'b0);
        cnts("rst_stall_rst", 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0; clr(); #1;
        br(1'b0, 5'd5, 5'd6, 1'b1);
        #1 outs("rst_stall_idle", 1'b0, 1'b0, 1'b0);
        @(negedge clk); clr(); #1;
        cnts("rst_stall_idle", 16'd0, 16'd1);

        // Drive taken_cnt to 0xFFFE, then three more must saturate
        br(1'b1, 5'd3, 5'd4, 1'b1);
        repeat (16'hFFFE) @(negedge clk);
        clr(); #1;
        cnts("sat_pre", 16'hFFFE, 16'd1);
        br(1'b1, 5'd3, 5'd4, 1'b1);
        #1 outs("sat_br", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        clr(); #1;
        cnts("sat_top", 16'hFFFF, 16'd1);
        @(negedge clk); #1;
        cnts("sat_hold", 16'hFFFF, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
